// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with accumulator, shift-add multiply and restoring divide
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             USE_ACC,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             CAR,
  output logic             OVF,
  output logic             ERR,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_MOD  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FIN} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   op_a;
  logic               iter_op;
  logic [WIDTH:0]     add_sum, sub_sum;
  logic [WIDTH:0]     mul_acc;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;

  // Operand selection at acceptance and per-iteration datapath arithmetic
  always_comb begin
    op_a      = USE_ACC ? OUT : IN1;
    iter_op   = (OP == OP_MUL) || (((OP == OP_DIV) || (OP == OP_MOD)) && (IN2 != '0));
    add_sum   = {1'b0, a_r} + {1'b0, b_r};
    sub_sum   = {1'b0, a_r} + {1'b0, ~b_r} + (WIDTH+1)'(1);
    // Shift-add: add multiplicand into the high half when the multiplier LSB is set, then shift right
    mul_acc   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    mul_next  = {mul_acc, prod[WIDTH-1:1]};
    // Restoring division: shift next dividend bit into the remainder, subtract if it fits
    div_shift = {rem, quo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_r};
    div_diff  = div_shift[WIDTH-1:0] - b_r;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (START) state_nxt = iter_op ? S_ITER : S_EXEC;
      S_EXEC: state_nxt = S_IDLE;
      S_ITER: if (cnt == LAST_ITER) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers, results and handshake outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_r   <= OP_NOP;
      a_r    <= '0;
      b_r    <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      OUT    <= '0;
      OUT_HI <= '0;
      CAR    <= 1'b0;
      OVF    <= 1'b0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            op_r <= OP;
            a_r  <= op_a;
            b_r  <= IN2;
            prod <= {{WIDTH{1'b0}}, IN2};
            rem  <= '0;
            quo  <= op_a;
            cnt  <= '0;
            CAR  <= 1'b0;
            OVF  <= 1'b0;
            ERR  <= 1'b0;
            BUSY <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_r)
            OP_ADD: begin
              OUT <= add_sum[WIDTH-1:0];
              CAR <= add_sum[WIDTH];
              OVF <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
              OUT <= sub_sum[WIDTH-1:0];
              CAR <= sub_sum[WIDTH];
              OVF <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_LOAD: OUT <= a_r;
            OP_CLR:  OUT <= '0;
            OP_DIV, OP_MOD: begin
              OUT <= '0;
              ERR <= 1'b1;
            end
            default: OUT <= OUT;
          endcase
          OUT_HI <= '0;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
        end
        S_ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r == OP_MUL) begin
            prod <= mul_next;
          end else begin
            rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end
        end
        S_FIN: begin
          if (op_r == OP_MUL) begin
            OUT    <= prod[WIDTH-1:0];
            OUT_HI <= prod[2*WIDTH-1:WIDTH];
            OVF    <= prod[2*WIDTH-1:WIDTH] != '0;
          end else begin
            OUT    <= (op_r == OP_MOD) ? rem : quo;
            OUT_HI <= '0;
          end
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end
        default: BUSY <= 1'b0;
      endcase
    end
  end

endmodule
